// File: rtl/pipeline_hazard_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding controller.
// The tracked-entry rd field has a fixed width (HZ_RD_W). Narrower register
// addresses are zero-extended into it, so REG_AW must not exceed HZ_RD_W.
package pipeline_hazard_pkg;

  localparam int HZ_RD_W = 8;
  localparam int FWD_RF  = 0;   // forwarding select meaning "read register file"

  typedef logic [HZ_RD_W-1:0] hz_rd_t;

  typedef struct packed {
    logic   valid;
    hz_rd_t rd;
    logic   regwrite;
    logic   load;
  } hz_entry_t;

  // Width of a forwarding select that can name RF (0) or stages 1..fwd_stages.
  function automatic int sel_width(input int fwd_stages);
    return $clog2(fwd_stages + 1);
  endfunction

  // A producer only matters when it really writes a non-x0 register.
  function automatic logic is_live(input hz_entry_t e);
    return e.valid && e.regwrite && (e.rd != '0);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_src_match.sv
// hazard_src_match: per-operand hazard check against the tracked pipeline.
// Index 0 of i_ents is EX (position 0); index k is post-EX stage k.
// Produces the load-use stall request and the select the operand will need
// one cycle later, when every producer has moved one position older.
module hazard_src_match
  import pipeline_hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int FWD_STAGES = 2,
  parameter int LOAD_LAT   = 1,
  parameter int FW         = sel_width(FWD_STAGES)
) (
  input  logic [REG_AW-1:0]        i_rs,
  input  logic                     i_used,
  input  hz_entry_t [FWD_STAGES:0] i_ents,
  output logic                     o_stall_req,
  output logic [FW-1:0]            o_sel_nxt
);

  hz_rd_t w_rs;
  assign w_rs = hz_rd_t'(i_rs);

  // Scan oldest to youngest so the youngest matching producer wins the select.
  always_comb begin
    o_stall_req = 1'b0;
    o_sel_nxt   = FW'(FWD_RF);
    if (i_used && (w_rs != '0)) begin
      for (int p = FWD_STAGES; p >= 0; p--) begin
        if (is_live(i_ents[p]) && (i_ents[p].rd == w_rs)) begin
          if (i_ents[p].load && (p < LOAD_LAT)) o_stall_req = 1'b1;
          o_sel_nxt = (p < FWD_STAGES) ? FW'(p + 1) : FW'(FWD_RF);
        end
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: tracked-pipeline hazard and forwarding controller.
// Entry 0 is EX, entries 1..FWD_STAGES are the post-EX stages. Forwarding
// selects are registered alongside the EX entry they belong to.
// Optional statistics counters: define PIPELINE_HAZARD_CNT_EN to build them;
// otherwise stall_cnt/flush_cnt are tied to 0.
module pipeline_hazard_ctrl
  import pipeline_hazard_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int FWD_STAGES  = 2,
  parameter int LOAD_LAT    = 1,
  parameter int FLUSH_DEPTH = 1,
  parameter int CNT_W       = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             id_valid,
  input  logic [REG_AW-1:0]                id_rs1,
  input  logic [REG_AW-1:0]                id_rs2,
  input  logic                             id_rs1_used,
  input  logic                             id_rs2_used,
  input  logic [REG_AW-1:0]                id_rd,
  input  logic                             id_regwrite,
  input  logic                             id_memread,
  input  logic                             flush,
  output logic                             stall,
  output logic [sel_width(FWD_STAGES)-1:0] fwd_a,
  output logic [sel_width(FWD_STAGES)-1:0] fwd_b,
  output logic [CNT_W-1:0]                 stall_cnt,
  output logic [CNT_W-1:0]                 flush_cnt
);

  localparam int FW = sel_width(FWD_STAGES);

  hz_entry_t [FWD_STAGES:0] r_ent;
  logic [FW-1:0]            r_fwd_a;
  logic [FW-1:0]            r_fwd_b;

  hz_entry_t     w_id_ent;
  logic          w_req_a;
  logic          w_req_b;
  logic [FW-1:0] w_sel_a;
  logic [FW-1:0] w_sel_b;
  logic          w_stall;
  logic          w_issue;

  hazard_src_match #(
    .REG_AW(REG_AW), .FWD_STAGES(FWD_STAGES), .LOAD_LAT(LOAD_LAT), .FW(FW)
  ) u_match_a (
    .i_rs(id_rs1), .i_used(id_rs1_used), .i_ents(r_ent),
    .o_stall_req(w_req_a), .o_sel_nxt(w_sel_a)
  );

  hazard_src_match #(
    .REG_AW(REG_AW), .FWD_STAGES(FWD_STAGES), .LOAD_LAT(LOAD_LAT), .FW(FW)
  ) u_match_b (
    .i_rs(id_rs2), .i_used(id_rs2_used), .i_ents(r_ent),
    .o_stall_req(w_req_b), .o_sel_nxt(w_sel_b)
  );

  // Flush wins over stall; an empty ID slot never stalls.
  assign w_stall = id_valid && !flush && (w_req_a || w_req_b);
  assign w_issue = id_valid && !flush && !w_stall;

  // Pack the ID instruction into a tracking entry.
  always_comb begin
    w_id_ent          = '0;
    w_id_ent.valid    = 1'b1;
    w_id_ent.rd       = hz_rd_t'(id_rd);
    w_id_ent.regwrite = id_regwrite;
    w_id_ent.load     = id_memread;
  end

  // Shift the tracked pipeline, load EX, and kill the youngest entries on flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ent   <= '0;
      r_fwd_a <= '0;
      r_fwd_b <= '0;
    end else begin
      for (int k = 1; k <= FWD_STAGES; k++) begin
        if (flush && (k < FLUSH_DEPTH)) r_ent[k] <= '0;
        else                            r_ent[k] <= r_ent[k-1];
      end
      r_ent[0] <= w_issue ? w_id_ent : '0;
      r_fwd_a  <= w_issue ? w_sel_a : FW'(FWD_RF);
      r_fwd_b  <= w_issue ? w_sel_b : FW'(FWD_RF);
    end
  end

  assign stall = w_stall;
  assign fwd_a = r_fwd_a;
  assign fwd_b = r_fwd_b;

`ifdef PIPELINE_HAZARD_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Saturating event counters for the stall and flush statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (flush && (r_flush_cnt != '1))   r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl. Two instances: u_dut1 with default
// parameters, u_dut2 with FWD_STAGES=3, LOAD_LAT=2, FLUSH_DEPTH=2.
module tb_pipeline_hazard_ctrl;

`ifdef PIPELINE_HAZARD_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;

  // DUT1 signals
  logic       v1, u1a, u1b, rw1, mr1, fl1;
  logic [4:0] rs1a, rs1b, rd1;
  logic       stall1;
  logic [1:0] fa1, fb1;
  logic [31:0] sc1, fc1;

  // DUT2 signals
  logic       v2, u2a, u2b, rw2, mr2, fl2;
  logic [4:0] rs2a, rs2b, rd2;
  logic       stall2;
  logic [1:0] fa2, fb2;
  logic [31:0] sc2, fc2;

  int tests = 0;
  int fails = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl u_dut1 (
    .clk(clk), .reset(reset), .id_valid(v1), .id_rs1(rs1a), .id_rs2(rs1b),
    .id_rs1_used(u1a), .id_rs2_used(u1b), .id_rd(rd1), .id_regwrite(rw1),
    .id_memread(mr1), .flush(fl1), .stall(stall1), .fwd_a(fa1), .fwd_b(fb1),
    .stall_cnt(sc1), .flush_cnt(fc1)
  );

  pipeline_hazard_ctrl #(.FWD_STAGES(3), .LOAD_LAT(2), .FLUSH_DEPTH(2)) u_dut2 (
    .clk(clk), .reset(reset), .id_valid(v2), .id_rs1(rs2a), .id_rs2(rs2b),
    .id_rs1_used(u2a), .id_rs2_used(u2b), .id_rd(rd2), .id_regwrite(rw2),
    .id_memread(mr2), .flush(fl2), .stall(stall2), .fwd_a(fa2), .fwd_b(fb2),
    .stall_cnt(sc2), .flush_cnt(fc2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one ID slot on the selected DUT (the other sits idle).
  task automatic drive(input bit d2, input bit v, input logic [4:0] ra, input bit ua,
                       input logic [4:0] rb, input bit ub, input logic [4:0] rd,
                       input bit rw, input bit mr, input bit fl);
    v1 = 0; u1a = 0; u1b = 0; rw1 = 0; mr1 = 0; fl1 = 0; rs1a = 0; rs1b = 0; rd1 = 0;
    v2 = 0; u2a = 0; u2b = 0; rw2 = 0; mr2 = 0; fl2 = 0; rs2a = 0; rs2b = 0; rd2 = 0;
    if (!d2) begin
      v1 = v; rs1a = ra; u1a = ua; rs1b = rb; u1b = ub; rd1 = rd; rw1 = rw; mr1 = mr; fl1 = fl;
    end else begin
      v2 = v; rs2a = ra; u2a = ua; rs2b = rb; u2b = ub; rd2 = rd; rw2 = rw; mr2 = mr; fl2 = fl;
    end
  endtask

  // One pipeline cycle: check stall mid-cycle, then the EX selects after the edge.
  task automatic step(input string tag, input bit d2, input bit v,
                      input logic [4:0] ra, input bit ua, input logic [4:0] rb, input bit ub,
                      input logic [4:0] rd, input bit rw, input bit mr, input bit fl,
                      input bit es, input logic [1:0] efa, input logic [1:0] efb);
    logic [3:0] e;
    drive(d2, v, ra, ua, rb, ub, rd, rw, mr, fl);
    exp_q.push_back({efa, efb});
    @(negedge clk);
    chk({tag, "_stall"}, d2 ? 32'(stall2) : 32'(stall1), 32'(es));
    @(posedge clk); #1;
    e = exp_q.pop_front();
    chk({tag, "_fwd_a"}, d2 ? 32'(fa2) : 32'(fa1), 32'(e[3:2]));
    chk({tag, "_fwd_b"}, d2 ? 32'(fb2) : 32'(fb1), 32'(e[1:0]));
  endtask

  task automatic idle(input bit d2, input int n);
    for (int i = 0; i < n; i++) begin
      drive(d2, 0, 5'($urandom_range(0, 31)), 0, 5'($urandom_range(0, 31)), 0, 0, 0, 0, 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(stall1), 0);
    chk("rst_fwd_a", 32'(fa1), 0);
    chk("rst_fwd_b", 32'(fb1), 0);
    chk("rst_stall_cnt", sc1, 0);
    chk("rst_flush_cnt", fc1, 0);
    reset = 0;
    @(posedge clk); #1;

    // ALU producer followed directly by consumer -> EX/MEM forward
    step("a_prod", 0, 1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 0);
    step("a_cons", 0, 1, 5, 1, 0, 1, 10, 1, 0, 0, 0, 1, 0);
    idle(0, 4);
    // one instruction apart -> MEM/WB forward
    step("b_prod", 0, 1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 0);
    step("b_gap", 0, 1, 1, 1, 2, 1, 11, 1, 0, 0, 0, 0, 0);
    step("b_cons", 0, 1, 5, 1, 0, 0, 12, 1, 0, 0, 0, 2, 0);
    idle(0, 4);
    // two apart -> out of window, register file
    step("c_prod", 0, 1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 0);
    step("c_gap1", 0, 1, 1, 1, 2, 1, 11, 1, 0, 0, 0, 0, 0);
    step("c_gap2", 0, 1, 1, 1, 2, 1, 12, 1, 0, 0, 0, 0, 0);
    step("c_cons", 0, 1, 0, 0, 5, 1, 13, 1, 0, 0, 0, 0, 0);
    idle(0, 4);
    // load-use: one stall cycle with bubble, then forward from stage 2
    step("d_load", 0, 1, 1, 1, 0, 0, 6, 1, 1, 0, 0, 0, 0);
    step("d_use0", 0, 1, 6, 1, 2, 1, 14, 1, 0, 0, 1, 0, 0);
    step("d_use1", 0, 1, 6, 1, 2, 1, 14, 1, 0, 0, 0, 2, 0);
    chk("d_stall_cnt", sc1, CNT_EN ? 32'd1 : 32'd0);
    idle(0, 4);
    // two in-flight writers of x7 -> youngest wins
    step("e_w1", 0, 1, 1, 1, 2, 1, 7, 1, 0, 0, 0, 0, 0);
    step("e_w2", 0, 1, 1, 1, 2, 1, 7, 1, 0, 0, 0, 0, 0);
    step("e_cons", 0, 1, 7, 1, 7, 1, 16, 1, 0, 0, 0, 1, 1);
    idle(0, 4);
    // x0 writer, non-writing producer, unused source
    step("f_wx0", 0, 1, 1, 1, 2, 1, 0, 1, 0, 0, 0, 0, 0);
    step("f_rx0", 0, 1, 0, 1, 0, 1, 17, 1, 0, 0, 0, 0, 0);
    step("f_st8", 0, 1, 1, 1, 2, 1, 8, 0, 0, 0, 0, 0, 0);
    step("f_r8", 0, 1, 8, 1, 0, 0, 18, 1, 0, 0, 0, 0, 0);
    step("f_w15", 0, 1, 1, 1, 2, 1, 15, 1, 0, 0, 0, 0, 0);
    step("f_r15", 0, 1, 15, 0, 15, 1, 19, 1, 0, 0, 0, 0, 1);
    idle(0, 4);
    // load-use coincident with flush: no stall, bubble; load survives (depth 1)
    step("g_load", 0, 1, 1, 1, 0, 0, 9, 1, 1, 0, 0, 0, 0);
    step("g_flush", 0, 1, 9, 1, 0, 0, 20, 1, 0, 1, 0, 0, 0);
    step("g_use", 0, 1, 9, 1, 0, 0, 20, 1, 0, 0, 0, 2, 0);
    chk("g_stall_cnt", sc1, CNT_EN ? 32'd1 : 32'd0);
    chk("g_flush_cnt", fc1, CNT_EN ? 32'd1 : 32'd0);
    idle(0, 4);

    // DUT2: LOAD_LAT=2 -> two stall cycles, then select 3
    step("h_load", 1, 1, 1, 1, 0, 0, 6, 1, 1, 0, 0, 0, 0);
    step("h_use0", 1, 1, 6, 1, 0, 0, 21, 1, 0, 0, 1, 0, 0);
    step("h_use1", 1, 1, 6, 1, 0, 0, 21, 1, 0, 0, 1, 0, 0);
    step("h_use2", 1, 1, 6, 1, 0, 0, 21, 1, 0, 0, 0, 3, 0);
    idle(1, 5);
    // DUT2 control: x13 one apart forwards from stage 2
    step("i_prod", 1, 1, 1, 1, 0, 0, 13, 1, 0, 0, 0, 0, 0);
    step("i_gap", 1, 1, 1, 1, 0, 0, 14, 1, 0, 0, 0, 0, 0);
    step("i_cons", 1, 1, 13, 1, 0, 0, 22, 1, 0, 0, 0, 2, 0);
    idle(1, 5);
    // DUT2 FLUSH_DEPTH=2: the flush also kills the x13 entry entering s[1]
    step("j_prod", 1, 1, 1, 1, 0, 0, 13, 1, 0, 0, 0, 0, 0);
    step("j_flush", 1, 1, 1, 1, 0, 0, 14, 1, 0, 1, 0, 0, 0);
    step("j_cons", 1, 1, 13, 1, 0, 0, 22, 1, 0, 0, 0, 0, 0);
    chk("j_stall_cnt2", sc2, CNT_EN ? 32'd2 : 32'd0);
    chk("j_flush_cnt2", fc2, CNT_EN ? 32'd1 : 32'd0);
    idle(1, 5);

    // reset mid-stall on DUT1
    step("k_load", 0, 1, 1, 1, 0, 0, 12, 1, 1, 0, 0, 0, 0);
    drive(0, 1, 12, 1, 0, 0, 23, 1, 0, 0);
    @(negedge clk);
    chk("k_stall_pre", 32'(stall1), 1);
    #2 reset = 1;
    #1;
    chk("k_stall_rst", 32'(stall1), 0);
    chk("k_fwd_a_rst", 32'(fa1), 0);
    chk("k_fwd_b_rst", 32'(fb1), 0);
    chk("k_stall_cnt", sc1, 0);
    chk("k_flush_cnt", fc1, 0);
    chk("k_stall_cnt2", sc2, 0);
    @(posedge clk); #1;
    reset = 0;
    step("k_use", 0, 1, 12, 1, 0, 0, 23, 1, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
